// File: rtl/wait_state_memory.sv
// wait_state_memory: byte-enabled word RAM with fixed response latency, error decode and post-reset clear sweep
module wait_state_memory #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int LATENCY = 2,
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter bit STRICT_ALIGN = 1'b0,
   localparam int BE_W = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [BE_W-1:0]       req_be,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  busy
);
   localparam int OFF_W = $clog2(BE_W);
   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BE_W - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH_WORDS - 1);
   typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [3:0] cnt_q, cnt_d;
   logic write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0] be_q, be_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic err_q, err_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic accept, commit, src_write, src_err;
   logic [ADDR_WIDTH-1:0] src_addr, word_full;
   logic [DATA_WIDTH-1:0] src_wdata;
   logic [BE_W-1:0] src_be;
   logic [IDX_W-1:0] idx;
   // state and request/response registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   // live request is used when LATENCY=1 commits on the accept edge itself
   always_comb begin
      accept    = req_valid && req_ready;
      src_write = (state_q == IDLE) ? req_write : write_q;
      src_addr  = (state_q == IDLE) ? req_addr : addr_q;
      src_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
      src_be    = (state_q == IDLE) ? req_be : be_q;
      word_full = src_addr >> OFF_W;
      idx       = word_full[IDX_W-1:0];
      src_err   = (word_full >= DEPTH_A) || (STRICT_ALIGN && ((src_addr & LOW_MASK) != '0));
   end
   // next-state, clear pointer, countdown and request capture
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      case (state_q)
         CLEAR: begin
            ptr_d   = (ptr_q == LAST) ? '0 : ptr_q + IDX_W'(1);
            state_d = (ptr_q == LAST) ? IDLE : CLEAR;
         end
         IDLE: begin
            if (accept) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = 4'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? RESP : WAIT;
         end
         default: state_d = IDLE;
      endcase
   end
   // response data is captured on the edge that enters RESP and zeroed otherwise
   always_comb begin
      commit  = (state_d == RESP) && (state_q != RESP);
      rdata_d = (commit && !src_write && !src_err) ? mem[idx] : '0;
      err_d   = commit && src_err;
   end
   // outputs decoded from the registered state
   always_comb begin
      req_ready  = (state_q == IDLE) && !reset;
      resp_valid = state_q == RESP;
      resp_rdata = rdata_q;
      resp_err   = err_q;
      busy       = state_q == CLEAR;
   end
   // array: zero sweep during CLEAR, lane-gated write at commit
   always_ff @(posedge clk) begin
      if (state_q == CLEAR)
         mem[ptr_q] <= '0;
      else if (commit && src_write && !src_err)
         for (int i = 0; i < BE_W; i++)
            if (src_be[i]) mem[idx][8*i +: 8] <= src_wdata[8*i +: 8];
   end
endmodule

// File: tb/tb_wait_state_memory.sv
// tb_wait_state_memory: three parameter variants driven in lockstep against a word/byte-lane reference model
module tb_wait_state_memory;
   localparam int N = 3;
   localparam int DEPTH = 256;
   function automatic int lat_of(input int g);
      return (g == 0) ? 2 : (g == 1) ? 1 : 4;
   endfunction
   function automatic bit clr_of(input int g);
      return g != 2;
   endfunction
   function automatic bit strict_of(input int g);
      return g == 1;
   endfunction
   logic clk = 1'b0;
   logic reset;
   logic req_valid, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0] req_be;
   logic [N-1:0] req_ready, resp_valid, resp_err, busy;
   logic [31:0] resp_rdata [N];
   logic [31:0] mm [N][DEPTH];
   bit kn [N][DEPTH];
   logic [31:0] got_rd [N];
   bit got_er [N];
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < N; g++) begin : gi
      wait_state_memory #(
         .LATENCY(lat_of(g)),
         .CLEAR_ON_RESET(clr_of(g)),
         .STRICT_ALIGN(strict_of(g))
      ) dut (
         .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[g]),
         .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
         .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]), .busy(busy[g])
      );
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic wait_ready();
      int n = 0;
      while (req_ready !== {N{1'b1}} && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_wait", 32'(n < 500), 1);
   endtask
   task automatic model_clear();
      for (int g = 0; g < N; g++)
         for (int w = 0; w < DEPTH; w++)
            if (clr_of(g)) begin
               mm[g][w] = '0;
               kn[g][w] = 1'b1;
            end
   endtask
   task automatic xact(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int pulses [N];
      int at [N];
      bit tim_ok [N];
      logic [31:0] exp_rd [N];
      bit exp_er [N];
      bit known [N];
      int idx;
      wait_ready();
      idx = int'(a >> 2);
      for (int g = 0; g < N; g++) begin
         exp_er[g] = (idx >= DEPTH) || (strict_of(g) && a[1:0] != 2'b00);
         known[g]  = exp_er[g] || wr || kn[g][exp_er[g] ? 0 : idx];
         exp_rd[g] = (exp_er[g] || wr) ? 32'h0 : mm[g][idx];
         pulses[g] = 0;
         at[g]     = -1;
         tim_ok[g] = 1'b1;
         got_rd[g] = '0;
         got_er[g] = 1'b0;
         if (wr && !exp_er[g]) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) mm[g][idx][8*i +: 8] = d[8*i +: 8];
            kn[g][idx] = kn[g][idx] || (be == 4'hF);
         end
      end
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int j = 0; j < 6; j++) begin
         if (j > 0) begin
            @(posedge clk); #1;
         end
         for (int g = 0; g < N; g++) begin
            if (resp_valid[g]) begin
               pulses[g]++;
               at[g]     = j;
               got_rd[g] = resp_rdata[g];
               got_er[g] = resp_err[g];
            end
            if (req_ready[g] !== (j >= lat_of(g))) tim_ok[g] = 1'b0;
            if (!resp_valid[g] && resp_rdata[g] !== 32'h0) tim_ok[g] = 1'b0;
         end
      end
      for (int g = 0; g < N; g++) begin
         chk($sformatf("latency[%0d] a=%h", g, a), 32'(at[g] + 1), 32'(lat_of(g)));
         chk($sformatf("pulses[%0d] a=%h", g, a), 32'(pulses[g]), 1);
         chk($sformatf("ready_rdata_shape[%0d] a=%h", g, a), 32'(tim_ok[g]), 1);
         chk($sformatf("err[%0d] a=%h", g, a), 32'(got_er[g]), 32'(exp_er[g]));
         if (known[g]) chk($sformatf("rdata[%0d] a=%h", g, a), got_rd[g], exp_rd[g]);
      end
   endtask
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rd;
      bit          err;
   } vec_t;
   vec_t vt [$];
   task automatic add_v(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [31:0] rd, input bit err);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = d; v.be = be; v.rd = rd; v.err = err;
      vt.push_back(v);
   endtask
   initial begin
      int n;
      bit busy_ok, quiet;
      add_v(0, 32'h000, 32'h0, 4'h0, 32'h00000000, 0);
      add_v(0, 32'h100, 32'h0, 4'h0, 32'h00000000, 0);
      add_v(1, 32'h000, 32'h12345678, 4'hF, 32'h0, 0);
      add_v(0, 32'h000, 32'h0, 4'h0, 32'h12345678, 0);
      add_v(1, 32'h008, 32'h00000000, 4'hF, 32'h0, 0);
      add_v(1, 32'h008, 32'hAABBCCDD, 4'h1, 32'h0, 0);
      add_v(0, 32'h008, 32'h0, 4'h0, 32'h000000DD, 0);
      add_v(1, 32'h008, 32'hAABBCCDD, 4'h2, 32'h0, 0);
      add_v(0, 32'h008, 32'h0, 4'h0, 32'h0000CCDD, 0);
      add_v(1, 32'h008, 32'hAABBCCDD, 4'hC, 32'h0, 0);
      add_v(0, 32'h008, 32'h0, 4'h0, 32'hAABBCCDD, 0);
      add_v(1, 32'h008, 32'h11223344, 4'h0, 32'h0, 0);
      add_v(0, 32'h008, 32'h0, 4'h0, 32'hAABBCCDD, 0);
      add_v(1, 32'h3FC, 32'hFFFFFFFF, 4'hF, 32'h0, 0);
      add_v(0, 32'h3FC, 32'h0, 4'h0, 32'hFFFFFFFF, 0);
      add_v(1, 32'h400, 32'h55555555, 4'hF, 32'h0, 1);
      add_v(0, 32'h000, 32'h0, 4'h0, 32'h12345678, 0);
      add_v(0, 32'h400, 32'h0, 4'h0, 32'h00000000, 1);
      add_v(1, 32'h040, 32'hABCDEF00, 4'hF, 32'h0, 0);
      add_v(0, 32'h041, 32'h0, 4'h0, 32'hABCDEF00, 0);
      add_v(0, 32'h042, 32'h0, 4'h0, 32'hABCDEF00, 0);
      add_v(0, 32'h043, 32'h0, 4'h0, 32'hABCDEF00, 0);
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = '0;
      for (int g = 0; g < N; g++) kn[g] = '{default: 1'b0};
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < N; g++) begin
         chk($sformatf("rst_ready[%0d]", g), 32'(req_ready[g]), 0);
         chk($sformatf("rst_valid[%0d]", g), 32'(resp_valid[g]), 0);
         chk($sformatf("rst_rdata[%0d]", g), resp_rdata[g], 0);
         chk($sformatf("rst_err[%0d]", g), 32'(resp_err[g]), 0);
         chk($sformatf("rst_busy[%0d]", g), 32'(busy[g]), 32'(clr_of(g)));
      end
      reset = 1'b0;
      #1;
      chk("noclear_ready", 32'(req_ready[2]), 1);
      chk("noclear_busy", 32'(busy[2]), 0);
      n = 0; busy_ok = 1'b1;
      while (!req_ready[0] && n < 400) begin
         if (!busy[0]) busy_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      chk("clear_cycles", 32'(n), 256);
      chk("clear_busy_high", 32'(busy_ok), 1);
      chk("clear_busy_drop", 32'(busy[0]), 0);
      foreach (vt[k]) begin
         xact(vt[k].wr, vt[k].addr, vt[k].wdata, vt[k].be);
         chk($sformatf("vec%0d_rdata", k), got_rd[0], vt[k].rd);
         chk($sformatf("vec%0d_err", k), 32'(got_er[0]), 32'(vt[k].err));
      end
      chk("strict_041_err", 32'(got_er[1]), 1);
      xact(0, 32'h041, 32'h0, 4'h0);
      chk("strict_041_rdata", got_rd[1], 0);
      xact(1, 32'h004, 32'h11111111, 4'hF);
      wait_ready();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h004;
      req_wdata = 32'hDEADBEEF; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      quiet = 1'b1;
      for (int j = 0; j < 6; j++) begin
         #1;
         if (resp_valid !== '0) quiet = 1'b0;
         @(posedge clk); #1;
      end
      chk("abort_no_resp", 32'(quiet), 1);
      reset = 1'b0;
      model_clear();
      xact(0, 32'h004, 32'h0, 4'h0);
      chk("abort_preserved", got_rd[2], 32'h11111111);
      chk("abort_cleared", got_rd[0], 32'h0);
      for (int k = 0; k < 150; k++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 9) == 0) ? 32'h400 + $urandom_range(0, 31) : $urandom_range(0, 32'h3FF);
         xact($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
